// File: rtl/sram_ctrl_param.sv
// Multi-beat controller bridging a DATA_W CPU word access to a narrow asynchronous SRAM.
// Optional byte masking is enabled with `define SRAM_BYTE_MASK_EN (requires SRAM_DW=16).
module sram_ctrl_param #(
  parameter int DATA_W   = 32,
  parameter int SRAM_DW  = 16,
  parameter int SRAM_AW  = 18,
  parameter int WAIT_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [31:0]          address,
  input  logic [DATA_W-1:0]    write_data,
`ifdef SRAM_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0]  byte_en,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
`endif
  output logic [DATA_W-1:0]    read_data,
  output logic                 ready,
  inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                 SRAM_WE_N
);

  localparam int BEATS = DATA_W / SRAM_DW;
  localparam int BB    = SRAM_DW / 8;
  localparam int AS    = $clog2(BB);
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WW    = $clog2(WAIT_CYC + 1);
  localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WAIT_CYC);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t              state_q;
  logic                is_wr_q;
  logic [SRAM_AW-1:0]  base_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [KW-1:0]       k_q;
  logic [WW-1:0]       w_q;
  logic [SRAM_AW-1:0]  addr_q;
  logic                we_n_q;
  logic                oe_q;
  logic [SRAM_DW-1:0]  dq_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                start_d, w_last_d, k_last_d, new_beat_d, nwr_d, beat_en_d;
  logic [KW-1:0]       nk_d;
  logic [SRAM_AW-1:0]  nbase_d;
  logic [DATA_W-1:0]   nwdata_d;
  logic                unused_addr;

`ifdef SRAM_BYTE_MASK_EN
  logic [DATA_W/8-1:0] be_q;
  logic [DATA_W/8-1:0] nbe_d;
  logic                ub_n_q, lb_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
`endif

  assign unused_addr = ^address;

  // Next-beat values come from the live inputs on the launching IDLE cycle, else from latches.
  always_comb begin
    start_d    = (state_q == IDLE) && (rd_en || wr_en);
    w_last_d   = (w_q == W_LAST);
    k_last_d   = (k_q == K_LAST);
    new_beat_d = start_d || ((state_q == BEAT) && w_last_d && !k_last_d);
    nk_d       = start_d ? '0 : k_q + 1'b1;
    nwr_d      = start_d ? wr_en : is_wr_q;
    nbase_d    = start_d ? address[SRAM_AW-1+AS:AS] : base_q;
    nwdata_d   = start_d ? write_data : wdata_q;
`ifdef SRAM_BYTE_MASK_EN
    nbe_d      = start_d ? byte_en : be_q;
    beat_en_d  = |nbe_d[nk_d*BB +: BB];
`else
    beat_en_d  = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      k_q     <= '0;
      w_q     <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dq_q    <= '0;
      rdata_q <= '0;
`ifdef SRAM_BYTE_MASK_EN
      be_q    <= '0;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: if (start_d) begin
          state_q <= BEAT;
          is_wr_q <= wr_en;
          base_q  <= nbase_d;
          wdata_q <= write_data;
          k_q     <= '0;
          w_q     <= '0;
`ifdef SRAM_BYTE_MASK_EN
          be_q    <= byte_en;
`endif
        end
        BEAT: if (w_last_d) begin
          if (!is_wr_q) rdata_q[k_q*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
          w_q <= '0;
          if (k_last_d) state_q <= DONE;
          else          k_q     <= k_q + 1'b1;
        end else begin
          w_q <= w_q + 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // Pin outputs are registered; WE_N rises one cycle before the beat ends to hold data.
      if (new_beat_d) begin
        addr_q <= nbase_d + SRAM_AW'(nk_d);
        dq_q   <= nwdata_d[nk_d*SRAM_DW +: SRAM_DW];
        oe_q   <= nwr_d;
        we_n_q <= !(nwr_d && beat_en_d);
`ifdef SRAM_BYTE_MASK_EN
        lb_n_q <= nwr_d ? ~nbe_d[nk_d*2]     : 1'b0;
        ub_n_q <= nwr_d ? ~nbe_d[nk_d*2 + 1] : 1'b0;
`endif
      end else if ((state_q == BEAT) && w_last_d) begin
        oe_q   <= 1'b0;
        we_n_q <= 1'b1;
`ifdef SRAM_BYTE_MASK_EN
        lb_n_q <= 1'b1;
        ub_n_q <= 1'b1;
`endif
      end else if ((state_q == BEAT) && ((w_q + 1'b1) == W_LAST)) begin
        we_n_q <= 1'b1;
      end
    end
  end

  assign ready     = (state_q == DONE) || ((state_q == IDLE) && !(rd_en || wr_en));
  assign read_data = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_DQ   = oe_q ? dq_q : {SRAM_DW{1'bz}};

endmodule
